uart_tx_arbiter: RTL

Round-robin controller that shares the single `uart_tx` unit among `NUM_REQ` byte producers. It sits between the requesters and `uart_tx`. It accepts one byte at a time over a valid/ready handshake, issues a one-cycle start to the transmitter, and holds off further grants until the transmitter reports completion. This lets several design blocks print over one UART pin without coordinating with each other.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// ID_PREFIX and id_byte are used only when UART_ARB_ID_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ID_START = 3'd1,
    ID_WAIT  = 3'd2,
    START    = 3'd3,
    WAIT     = 3'd4
  } arb_state_t;

  localparam logic [3:0] ID_PREFIX = 4'hA;

  // Tag byte announcing which requester owns the following data byte
  function automatic logic [7:0] id_byte(input logic [3:0] idx);
    return {ID_PREFIX, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: starts at last+1 and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // First valid requester found after last wins; every candidate is visited once
  always_comb begin
    int  cand_s;
    logic hit_s;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s        = (int'(last) + k) % NUM_REQ;
      hit_s         = !any && req_valid[cand_s];
      grant[cand_s] = hit_s;
      idx           = hit_s ? IDX_W'(cand_s) : idx;
      any           = any | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers.
// Optional UART_ARB_ID_EN: each data byte is preceded by an ID byte {ID_PREFIX, grant_idx}.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  arb_state_t             state_r;
  arb_state_t             state_next_s;
  logic                   accept_s;
  logic [NUM_REQ-1:0]     arb_grant_s;
  logic [IDX_W-1:0]       arb_idx_s;
  logic                   arb_any_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;
  logic [DATA_WIDTH-1:0]  tx_data_r;
  logic [IDX_W-1:0]       grant_idx_r;
  logic [IDX_W-1:0]       last_r;
`ifdef UART_ARB_ID_EN
  logic [DATA_WIDTH-1:0]  data_hold_r;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .last      (last_r),
    .grant     (arb_grant_s),
    .idx       (arb_idx_s),
    .any       (arb_any_s)
  );

  // One-hot mux of the winning requester's byte
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = sel_data_s |
                   (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{arb_grant_s[i]}});
    end
  end

  // Next-state and acceptance decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_any_s && reset_n) begin
          accept_s     = 1'b1;
`ifdef UART_ARB_ID_EN
          state_next_s = ID_START;
`else
          state_next_s = START;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
`ifdef UART_ARB_ID_EN
      ID_START: state_next_s = ID_WAIT;
      ID_WAIT: begin
        if (tx_done) begin
          state_next_s = START;
        end else begin
          state_next_s = ID_WAIT;
        end
      end
`endif
      START: state_next_s = WAIT;
      WAIT: begin
        if (tx_done) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Grant bookkeeping and the byte presented to uart_tx
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data_r   <= '0;
      grant_idx_r <= '0;
      last_r      <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_ID_EN
      data_hold_r <= '0;
`endif
    end else if (accept_s) begin
      grant_idx_r <= arb_idx_s;
      last_r      <= arb_idx_s;
`ifdef UART_ARB_ID_EN
      tx_data_r   <= id_byte(4'(arb_idx_s));
      data_hold_r <= sel_data_s;
    end else if (state_r == ID_WAIT && tx_done) begin
      tx_data_r   <= data_hold_r;
`else
      tx_data_r   <= sel_data_s;
`endif
    end
  end

  assign req_ready = arb_grant_s & {NUM_REQ{accept_s}};
  assign tx_data   = tx_data_r;
  assign grant_idx = grant_idx_r;
  assign busy      = (state_r != IDLE);
`ifdef UART_ARB_ID_EN
  assign tx_start  = (state_r == START) || (state_r == ID_START);
`else
  assign tx_start  = (state_r == START);
`endif

endmodule
